pwl_wave_player: RTL and testbench
==================================

// Module: pwl_wave_player
// PURPOSE
//  Consumer end of IParams (modport in): plays the piecewise-linear waveform held there as a sample stream to the DAC path.
//  Snapshots all parameters on start; steps segment by segment with a fixed-point accumulator.
//  Repeats the whole waveform repeatcycle times; emits samples on an AXI-Stream-style master port.
// PARAMETERS
//  PARAM_SIZE  32  width of every IParams word; must match the IParams instance
//  POINTS      9   points per waveform; segments = POINTS-1
//  DATA_W      16  output sample width, signed, DATA_W <= PARAM_SIZE
//  FRAC        16  fractional bits of slope (linet_int) and accumulator
// PORTS
//  aclk         in   1           single clock; all logic rising-edge
//  aresetn      in   1           asynchronous, active-low reset
//  params       in   IParams.in  linea[k]: start amplitude (signed int); linet[k]: samples in segment k (unsigned);
//                                linet_int[k]: signed per-sample slope, Q.FRAC; linenmb: segments used; repeatcycle: 0 = forever
//  start        in   1           1-cycle pulse; honoured only in IDLE
//  stop         in   1           1-cycle pulse; abort request
//  m_tdata      out  DATA_W      sample
//  m_tvalid     out  1           sample valid
//  m_tready     in   1           sink ready
//  m_tlast      out  1           high on last sample of each waveform pass
//  busy         out  1           high in any state but IDLE
//  done         out  1           1-cycle pulse: run finished normally or via stop
// BEHAVIOUR
//  Reset: state=IDLE; m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, done=0; accumulator, counters, shadows cleared.
//  Reset asserted mid-run: same values immediately (async). No sample completes after reset.
//  start in IDLE: copy all IParams fields into shadow registers that cycle.
//    nseg = min(linenmb, POINTS-1). Go to LOAD with seg=0, rep=1.
//    Later IParams changes do not affect the run. start outside IDLE: ignored.
//  nseg==0 at start: no samples; done pulses the next cycle; back to IDLE.
//  LOAD (1 cycle, m_tvalid=0): if shadow linet[seg]==0, skip the segment: seg+1, stay in LOAD.
//    Otherwise acc = {sext(linea[seg]), FRAC'b0}; scnt=linet[seg]-1; go to RUN.
//  RUN: m_tvalid=1. m_tdata = acc integer part, DATA_W LSBs (see CONFIGURATION).
//    Values held stable while m_tvalid && !m_tready.
//    On handshake: acc += sext(linet_int[seg]); scnt -= 1.
//    Handshake with scnt==0 ends the segment: next seg -> LOAD.
//  Segment k emits exactly linet[k] samples: linea[k] + i*slope, i=0..linet[k]-1.
//  Each LOAD costs one bubble cycle; no combinational tready->tvalid path.
//  m_tlast=1 on the final sample of the last non-empty segment of a pass.
//  End of pass: if repeatcycle!=0 and rep==repeatcycle, then done pulse, IDLE.
//    Else rep+1 (saturating at max; no wrap), seg=0, LOAD.
//  Pass with all segments empty: done, IDLE. Never loops forever with no output.
//  Accumulator width PARAM_SIZE+FRAC, two's complement. Internal overflow wraps silently.
//  stop: latched as pending. Abort takes effect in LOAD, or on the handshake of the current RUN sample.
//    m_tvalid is never dropped without a handshake. Then done pulses, IDLE.
//    stop in IDLE: no effect. stop together with start in IDLE: start wins; stop discarded.
//  done and start in the same cycle: done pulses; start is accepted, since state is IDLE that cycle.
// CONFIGURATION
//  PWL_SAT_EN defined: integer part of acc clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before output.
//  PWL_SAT_EN undefined: m_tdata = low DATA_W bits of integer part (wraps).
//  No other behaviour differs.
// TESTING
//  Single ramp: nseg=1, linea[0]=0, linet[0]=4, linet_int[0]=0x10000, rep=1, tready=1
//    -> m_tdata 0,1,2,3; tlast on 3; done 1 cycle later.
//  Repeat + backpressure: same setup, rep=2, tready toggles 1/0
//    -> 8 samples 0..3,0..3; tdata stable while stalled; tlast on both 3s.
//  Empty segment + negative slope: nseg=2, linet={0,3}, linea[1]=10, linet_int[1]=-0x20000
//    -> 10,8,6; segment 0 produces nothing.
//  Saturation: DATA_W=16, linea[0]=32766, slope 0x10000, linet=4
//    -> with PWL_SAT_EN: 32766,32767,32767,32767. Without: 32766,32767,-32768,-32767.
//  Stop/reset: rep=0; stop pulse while stalled on sample 5 -> sample 5 still handshakes, done, busy=0.
//    aresetn low mid-RUN -> all outputs 0 at once.
//  Param change during run: rewrite linea[0] after start -> output unchanged until next start.

Source files
------------

// File: rtl/pwl_wave_player_if.sv
// Parameter block for the PWL player: per-point amplitude, length and slope plus run controls.
interface IParams #(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9
);
  logic [PARAM_SIZE-1:0] linea     [POINTS];
  logic [PARAM_SIZE-1:0] linet     [POINTS];
  logic [PARAM_SIZE-1:0] linet_int [POINTS];
  logic [PARAM_SIZE-1:0] linenmb;
  logic [PARAM_SIZE-1:0] repeatcycle;

  modport in  (input  linea, linet, linet_int, linenmb, repeatcycle);
  modport out (output linea, linet, linet_int, linenmb, repeatcycle);
endinterface

// File: rtl/pwl_wave_player.sv
// Plays a snapshotted piecewise-linear waveform as a stream; PWL_SAT_EN clamps samples instead of wrapping.
// Latency: start -> LOAD -> first sample two cycles later; one bubble cycle per segment load.
// Backpressure: sample held stable while m_tvalid && !m_tready; tvalid is a pure function of state.
module pwl_wave_player #(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9,
  parameter int DATA_W     = 16,
  parameter int FRAC       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  IParams.in                params,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = PARAM_SIZE + FRAC;
  localparam int SEG_W = $clog2(POINTS);
  localparam logic [PARAM_SIZE-1:0] MAX_SEG = PARAM_SIZE'(POINTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t state, state_d;

  logic [PARAM_SIZE-1:0] linea_sh     [POINTS];
  logic [PARAM_SIZE-1:0] linet_sh     [POINTS];
  logic [PARAM_SIZE-1:0] linet_int_sh [POINTS];
  logic [PARAM_SIZE-1:0] rep_sh;
  logic [SEG_W-1:0]      nseg;
  logic [SEG_W-1:0]      nseg_in;
  logic [SEG_W-1:0]      seg;
  logic [PARAM_SIZE-1:0] rep;
  logic [PARAM_SIZE-1:0] scnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      slope_ext;
  logic                  stop_pend;

  logic abort, rest_empty, rep_end;
  logic done_d, capture, load_seg, seg_inc, step, new_pass;
  logic [DATA_W-1:0] sample;

  assign nseg_in   = (params.linenmb > MAX_SEG) ? SEG_W'(POINTS - 1) : params.linenmb[SEG_W-1:0];
  assign abort     = stop_pend | stop;
  assign rep_end   = (rep_sh != '0) && (rep == rep_sh);
  assign slope_ext = {{FRAC{linet_int_sh[seg][PARAM_SIZE-1]}}, linet_int_sh[seg]};

  // A pass ends on the last sample of the last non-empty segment, so trailing empty ones cost nothing.
  always_comb begin
    rest_empty = 1'b1;
    for (int j = 0; j < POINTS; j++) begin
      if ((j > int'(seg)) && (j < int'(nseg)) && (linet_sh[j] != '0)) rest_empty = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    capture  = 1'b0;
    load_seg = 1'b0;
    seg_inc  = 1'b0;
    step     = 1'b0;
    new_pass = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (nseg_in == '0) done_d  = 1'b1;
          else               state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Reaching seg==nseg here means the whole pass was empty.
        if (abort || (seg == nseg)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (linet_sh[seg] == '0) begin
          seg_inc = 1'b1;
        end else begin
          load_seg = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (m_tready) begin
          step = 1'b1;
          if (abort) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (scnt == '0) begin
            if (!rest_empty) begin
              seg_inc = 1'b1;
              state_d = S_LOAD;
            end else if (rep_end) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              new_pass = 1'b1;
              state_d  = S_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < POINTS; k++) begin
        linea_sh[k]     <= '0;
        linet_sh[k]     <= '0;
        linet_int_sh[k] <= '0;
      end
      rep_sh    <= '0;
      nseg      <= '0;
      seg       <= '0;
      rep       <= '0;
      scnt      <= '0;
      acc       <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_d;
      if (capture) begin
        for (int k = 0; k < POINTS; k++) begin
          linea_sh[k]     <= params.linea[k];
          linet_sh[k]     <= params.linet[k];
          linet_int_sh[k] <= params.linet_int[k];
        end
        rep_sh <= params.repeatcycle;
        nseg   <= nseg_in;
        seg    <= '0;
        rep    <= PARAM_SIZE'(1);
      end
      if (seg_inc) seg <= seg + SEG_W'(1);
      if (new_pass) begin
        seg <= '0;
        if (rep != '1) rep <= rep + PARAM_SIZE'(1);
      end
      if (load_seg) begin
        acc  <= {linea_sh[seg], {FRAC{1'b0}}};
        scnt <= linet_sh[seg] - PARAM_SIZE'(1);
      end
      if (step) begin
        acc  <= acc + slope_ext;
        scnt <= scnt - PARAM_SIZE'(1);
      end
      // A stop seen in IDLE, or alongside the accepted start, must not abort the new run.
      if ((state == S_IDLE) || (state_d == S_IDLE)) stop_pend <= 1'b0;
      else if (stop)                                stop_pend <= 1'b1;
    end
  end

`ifdef PWL_SAT_EN
  localparam logic [PARAM_SIZE-1:0] SAT_MAX = {{(PARAM_SIZE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [PARAM_SIZE-1:0] SAT_MIN = ~SAT_MAX;
  logic [PARAM_SIZE-1:0] int_part;
  assign int_part = acc[ACC_W-1:FRAC];
  always_comb begin
    if ($signed(int_part) > $signed(SAT_MAX))      sample = SAT_MAX[DATA_W-1:0];
    else if ($signed(int_part) < $signed(SAT_MIN)) sample = SAT_MIN[DATA_W-1:0];
    else                                           sample = int_part[DATA_W-1:0];
  end
`else
  assign sample = acc[FRAC +: DATA_W];
`endif

  assign m_tvalid = (state == S_RUN);
  assign m_tdata  = m_tvalid ? sample : '0;
  assign m_tlast  = m_tvalid && (scnt == '0) && rest_empty;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_pwl_wave_player.sv
// Directed and randomized checks of pwl_wave_player against a sample-list reference model.
module tb_pwl_wave_player;
  localparam int PS = 32;
  localparam int NP = 9;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start, stop, m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, busy, done;

  IParams #(.PARAM_SIZE(PS), .POINTS(NP)) prm ();

  pwl_wave_player #(.PARAM_SIZE(PS), .POINTS(NP), .DATA_W(DW), .FRAC(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .params(prm), .start(start), .stop(stop),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;

  int total, bad, done_cnt;
  int la[NP], lt[NP], ls[NP];
  int lnmb, rep;
  logic [DW-1:0] got_dat[$], exp_dat[$];
  bit            got_last[$], exp_last[$];
  bit            prev_stall, prev_last;
  logic [DW-1:0] prev_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_params();
    for (int k = 0; k < NP; k++) begin la[k] = 0; lt[k] = 0; ls[k] = 0; end
    lnmb = 0; rep = 1;
  endtask

  task automatic apply();
    for (int k = 0; k < NP; k++) begin
      prm.linea[k] = la[k]; prm.linet[k] = lt[k]; prm.linet_int[k] = ls[k];
    end
    prm.linenmb = lnmb; prm.repeatcycle = rep;
  endtask

  // Expected stream straight from the waveform definition: linea + i*slope per segment, rep passes.
  task automatic build_model();
    int nseg, klast, ip32;
    longint acc;
    logic [DW-1:0] v;
    exp_dat.delete(); exp_last.delete();
    nseg = (lnmb > NP - 1) ? NP - 1 : lnmb;
    klast = -1;
    for (int k = 0; k < nseg; k++) if (lt[k] != 0) klast = k;
    for (int p = 0; p < rep; p++)
      for (int k = 0; k < nseg; k++)
        for (int i = 0; i < lt[k]; i++) begin
          acc  = longint'(la[k]) * 65536 + longint'(i) * longint'(ls[k]);
          ip32 = int'(acc >>> 16);
`ifdef PWL_SAT_EN
          if (ip32 > 32767)       v = 16'h7fff;
          else if (ip32 < -32768) v = 16'h8000;
          else                    v = ip32[15:0];
`else
          v = ip32[15:0];
`endif
          exp_dat.push_back(v);
          exp_last.push_back((k == klast) && (i == lt[k] - 1));
        end
  endtask

  task automatic cyc(input bit rdy, input bit stp, input bit st);
    @(negedge aclk);
    start = st; stop = stp; m_tready = rdy;
    #1;
    if (prev_stall) begin
      chk("stall_vld", m_tvalid, 1);
      chk("stall_dat", m_tdata, prev_dat);
      chk("stall_last", m_tlast, prev_last);
    end
    if (m_tvalid && rdy) begin got_dat.push_back(m_tdata); got_last.push_back(m_tlast); end
    if (done === 1'b1) done_cnt++;
    prev_stall = m_tvalid && !rdy;
    prev_dat   = m_tdata;
    prev_last  = m_tlast;
  endtask

  task automatic kick();
    @(negedge aclk);
    start = 1'b1; stop = 1'b0; m_tready = 1'b1;
    done_cnt = 0; prev_stall = 1'b0;
    got_dat.delete(); got_last.delete();
  endtask

  task automatic run_until_done(input int budget, input int stall_pct);
    int n0;
    for (int n = 0; n < budget && done_cnt == 0; n++)
      cyc(($urandom_range(99) >= stall_pct), 1'b0, 1'b0);
    chk("done_seen", done_cnt, 1);
    chk("idle_busy", busy, 0);
    n0 = got_dat.size();
    cyc(1'b1, 1'b0, 1'b0);
    chk("done_width", done_cnt, 1);
    chk("no_extra", got_dat.size(), n0);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      chk({tag, "_dat"}, got_dat[i], exp_dat[i]);
      chk({tag, "_last"}, got_last[i], exp_last[i]);
    end
    got_dat.delete(); got_last.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; m_tready = 1'b0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_dat = '0;
    clear_params(); apply();
    #12;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // single ramp
    clear_params(); lnmb = 1; lt[0] = 4; ls[0] = 32'h10000; rep = 1;
    apply(); build_model(); kick(); run_until_done(200, 0); compare("ramp");

    // repeat with backpressure
    rep = 2;
    apply(); build_model(); kick(); run_until_done(400, 50); compare("rep_bp");

    // empty segment then negative slope
    clear_params(); lnmb = 2; lt[0] = 0; lt[1] = 3; la[1] = 10; ls[1] = -131072;
    apply(); build_model(); kick(); run_until_done(200, 30); compare("neg");

    // saturate or wrap at the 16-bit boundary
    clear_params(); lnmb = 1; la[0] = 32766; ls[0] = 65536; lt[0] = 4;
    apply(); build_model(); kick(); run_until_done(200, 0); compare("sat");

    // zero segments: done the cycle after start, no samples
    clear_params(); lnmb = 0; lt[0] = 3;
    apply(); kick(); cyc(1'b1, 1'b0, 1'b0);
    chk("nseg0_done", done_cnt, 1);
    chk("nseg0_busy", busy, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("nseg0_width", done_cnt, 1);
    chk("nseg0_count", got_dat.size(), 0);

    // params rewritten mid-run, extra start while busy: both ignored
    clear_params(); lnmb = 2; la[0] = 5; la[1] = -3; lt[0] = 3; lt[1] = 2;
    ls[0] = 32'h8000; ls[1] = -65536; rep = 2;
    apply(); build_model(); kick();
    cyc(1'b1, 1'b0, 1'b0);
    prm.linea[0] = 1000; prm.linet[1] = 7;
    cyc(1'b1, 1'b0, 1'b1);
    run_until_done(400, 20); compare("pchg");
    la[0] = 1000; lt[1] = 7;
    apply(); build_model(); kick(); run_until_done(400, 20); compare("pchg2");

    // stop while stalled on sample 5 of an endless run
    clear_params(); lnmb = 1; lt[0] = 4; ls[0] = 65536; rep = 0;
    apply(); kick();
    for (int n = 0; n < 100 && got_dat.size() < 5; n++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_until_done(20, 0);
    exp_dat = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    compare("stop");

    // async reset in the middle of RUN
    apply(); kick();
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst_vld", m_tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    got_dat.delete(); got_last.delete(); prev_stall = 1'b0; done_cnt = 0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", got_dat.size(), 0);
    chk("post_rst_done", done_cnt, 0);

    // randomized waveforms
    for (int it = 0; it < 25; it++) begin
      lnmb = $urandom_range(10);
      for (int k = 0; k < NP; k++) begin
        lt[k] = ($urandom_range(3) == 0) ? 0 : $urandom_range(4, 1);
        la[k] = int'($urandom_range(80000)) - 40000;
        ls[k] = int'($urandom_range(32'h60000)) - 32'sh30000;
      end
      rep = $urandom_range(3, 1);
      apply(); build_model(); kick();
      run_until_done(3000, $urandom_range(60));
      compare("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
